// File: rtl/cpu_memory_responder_if.sv
// CPU memory bus plus byte-serial program-loader handshake for cpu_memory_responder.
interface cpu_memory_responder_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] memoryIn;
  logic [DATA_W-1:0] memoryOut;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic [ADDR_W:0]   load_count;
  logic              load_done;
  logic              cpu_hold;
  logic              conflict;

  modport master (
    output read, write, address, memoryIn, load_start, load_valid, load_data,
    input  memoryOut, load_ready, load_count, load_done, cpu_hold, conflict
  );

  modport slave (
    input  read, write, address, memoryIn, load_start, load_valid, load_data,
    output memoryOut, load_ready, load_count, load_done, cpu_hold, conflict
  );
endinterface

// File: rtl/cpu_memory_responder.sv
// Zero-wait-state word store for the CPU with a valid/ready program loader
// that holds the CPU in clear while memory is being filled.
module cpu_memory_responder #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOAD_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  cpu_memory_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(LOAD_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  loadPtr;
  logic [CNT_W-1:0]  loadCount;
  logic              loadDone;
  logic              conflictSeen;
  logic              cpuHold;
  logic              loadReady;
  logic              cpuStrobe;
  logic              lastByte;

  assign cpuStrobe = bus.read | bus.write;
  assign lastByte  = (loadPtr == LAST_PTR);

  // Next-state decode
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (bus.load_start) stateNext = LOAD;
      LOAD:    if (bus.load_valid && lastByte) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State, handshake flags and loader bookkeeping
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      cpuHold      <= 1'b0;
      loadReady    <= 1'b0;
      loadPtr      <= '0;
      loadCount    <= '0;
      loadDone     <= 1'b0;
      conflictSeen <= 1'b0;
    end else begin
      state     <= stateNext;
      cpuHold   <= (stateNext != IDLE);
      loadReady <= (stateNext == LOAD);
      unique case (state)
        IDLE: begin
          if (bus.load_start) begin
            loadPtr   <= '0;
            loadCount <= '0;
            loadDone  <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            loadPtr   <= loadPtr + CNT_W'(1);
            loadCount <= loadCount + CNT_W'(1);
          end
          if (cpuStrobe) conflictSeen <= 1'b1;
        end
        DONE: begin
          loadDone <= 1'b1;
          if (cpuStrobe) conflictSeen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Word store: CPU owns it in IDLE, the loader owns it in LOAD
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state == IDLE && bus.write)
        mem[bus.address] <= bus.memoryIn;
      else if (state == LOAD && bus.load_valid)
        mem[loadPtr[ADDR_W-1:0]] <= bus.load_data;
    end
  end

  // Read data is combinational so the CPU sees it with zero wait states
  assign bus.memoryOut  = (bus.read && state == IDLE && !cpuHold) ? mem[bus.address] : '0;
  assign bus.load_ready = loadReady;
  assign bus.load_count = loadCount;
  assign bus.load_done  = loadDone;
  assign bus.cpu_hold   = cpuHold;
  assign bus.conflict   = conflictSeen;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// Scoreboard bench: driver pushes expected outputs, a negedge monitor compares.
module tb_cpu_memory_responder;

  typedef struct {
    int         inst;
    string      name;
    logic [7:0] mo;
    logic       rdy;
    logic       hold;
    logic       done;
    logic       conf;
    logic [4:0] cnt;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clrS [2];
  logic       rd   [2];
  logic       wr   [2];
  logic       ls   [2];
  logic       lv   [2];
  logic [3:0] ad   [2];
  logic [7:0] mi   [2];
  logic [7:0] ld   [2];

  logic [7:0] oMo   [2];
  logic       oRdy  [2];
  logic       oHold [2];
  logic       oDone [2];
  logic       oConf [2];
  logic [4:0] oCnt  [2];

  // Reference state: memory image and expected status per instance
  logic [7:0] refMem [2][16];
  logic       eHold [2];
  logic       eRdy  [2];
  logic       eDone [2];
  logic       eConf [2];
  logic [4:0] eCnt  [2];

  expT sb [$];
  int  vectors = 0;
  int  miscompares = 0;

  cpu_memory_responder_if #(.ADDR_W(4), .DATA_W(8)) busA ();
  cpu_memory_responder_if #(.ADDR_W(4), .DATA_W(8)) busB ();

  cpu_memory_responder #(.ADDR_W(4), .DATA_W(8), .LOAD_WORDS(16)) dutA (
    .clk(clk), .clr(clrS[0]), .bus(busA));
  cpu_memory_responder #(.ADDR_W(4), .DATA_W(8), .LOAD_WORDS(4)) dutB (
    .clk(clk), .clr(clrS[1]), .bus(busB));

  assign busA.read = rd[0];  assign busA.write = wr[0];  assign busA.address = ad[0];
  assign busA.memoryIn = mi[0];  assign busA.load_start = ls[0];
  assign busA.load_valid = lv[0];  assign busA.load_data = ld[0];
  assign busB.read = rd[1];  assign busB.write = wr[1];  assign busB.address = ad[1];
  assign busB.memoryIn = mi[1];  assign busB.load_start = ls[1];
  assign busB.load_valid = lv[1];  assign busB.load_data = ld[1];

  assign oMo[0] = busA.memoryOut;  assign oRdy[0] = busA.load_ready;
  assign oHold[0] = busA.cpu_hold;  assign oDone[0] = busA.load_done;
  assign oConf[0] = busA.conflict;  assign oCnt[0] = busA.load_count;
  assign oMo[1] = busB.memoryOut;  assign oRdy[1] = busB.load_ready;
  assign oHold[1] = busB.cpu_hold;  assign oDone[1] = busB.load_done;
  assign oConf[1] = busB.conflict;  assign oCnt[1] = busB.load_count;

  // Monitor: compare every pending expectation mid-cycle
  always @(negedge clk) begin : monitor
    expT e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if ({oMo[e.inst], oRdy[e.inst], oHold[e.inst], oDone[e.inst], oConf[e.inst], oCnt[e.inst]}
          !== {e.mo, e.rdy, e.hold, e.done, e.conf, e.cnt}) begin
        miscompares++;
        $display("FAIL %s inst%0d: got mo=%h rdy=%b hold=%b done=%b conf=%b cnt=%0d, want mo=%h rdy=%b hold=%b done=%b conf=%b cnt=%0d",
                 e.name, e.inst, oMo[e.inst], oRdy[e.inst], oHold[e.inst], oDone[e.inst],
                 oConf[e.inst], oCnt[e.inst], e.mo, e.rdy, e.hold, e.done, e.conf, e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int inst, input string name);
    expT e;
    e.inst = inst;
    e.name = name;
    e.mo   = (rd[inst] && !eHold[inst]) ? refMem[inst][ad[inst]] : 8'h00;
    e.rdy  = eRdy[inst];
    e.hold = eHold[inst];
    e.done = eDone[inst];
    e.conf = eConf[inst];
    e.cnt  = eCnt[inst];
    sb.push_back(e);
  endtask

  task automatic clearModel(input int inst);
    for (int i = 0; i < 16; i++) refMem[inst][i] = 8'h00;
    eHold[inst] = 1'b0; eRdy[inst] = 1'b0; eDone[inst] = 1'b0;
    eConf[inst] = 1'b0; eCnt[inst] = 5'd0;
  endtask

  // One CPU cycle in IDLE; a write lands in the image after the edge
  task automatic cpuOp(input int inst, input bit r, input bit w, input logic [3:0] a,
                       input logic [7:0] d, input string name);
    rd[inst] = r; wr[inst] = w; ad[inst] = a; mi[inst] = d;
    chk(inst, name);
    step();
    if (w) refMem[inst][a] = d;
    rd[inst] = 1'b0; wr[inst] = 1'b0;
  endtask

  // Program load of lw bytes. base<0 gives random data; stallAt/stallLen force a stall,
  // randStall adds random gaps, poke drives a CPU write to word 0 during the forced stall,
  // abortAfter>=0 asserts clr after that many bytes, doneRead reads during the DONE cycle.
  task automatic doLoad(input int inst, input int lw, input int base, input int stallAt,
                        input int stallLen, input bit randStall, input bit poke,
                        input int abortAfter, input bit doneRead);
    logic [7:0] d;
    int stalls;
    ls[inst] = 1'b1;
    chk(inst, "load_start");
    step();
    ls[inst] = 1'b0;
    eHold[inst] = 1'b1; eRdy[inst] = 1'b1; eDone[inst] = 1'b0; eCnt[inst] = 5'd0;
    for (int i = 0; i < lw; i++) begin
      if (i == abortAfter) begin
        clrS[inst] = 1'b1;
        #1;
        clearModel(inst);
        rd[inst] = 1'b1; ad[inst] = 4'($urandom_range(0, 15));
        chk(inst, "abort");
        step();
        clrS[inst] = 1'b0; rd[inst] = 1'b0;
        return;
      end
      stalls = (i == stallAt) ? stallLen :
               ((randStall && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      for (int s = 0; s < stalls; s++) begin
        lv[inst] = 1'b0;
        if (poke && i == stallAt && s == 0) begin
          rd[inst] = 1'b1; wr[inst] = 1'b1; ad[inst] = 4'h0; mi[inst] = 8'hFF;
        end
        chk(inst, "stall");
        step();
        if (wr[inst]) eConf[inst] = 1'b1;
        rd[inst] = 1'b0; wr[inst] = 1'b0;
      end
      d = (base < 0) ? 8'($urandom) : 8'(base + i);
      lv[inst] = 1'b1; ld[inst] = d;
      ls[inst] = ($urandom_range(0, 3) == 0);
      chk(inst, "accept");
      step();
      lv[inst] = 1'b0; ls[inst] = 1'b0;
      refMem[inst][i] = d;
      eCnt[inst] = 5'(i + 1);
    end
    eRdy[inst] = 1'b0;
    ls[inst] = 1'b1;
    rd[inst] = doneRead; ad[inst] = 4'($urandom_range(0, 15));
    chk(inst, "done_cycle");
    step();
    if (doneRead) eConf[inst] = 1'b1;
    ls[inst] = 1'b0;
    eHold[inst] = 1'b0; eDone[inst] = 1'b1;
    rd[inst] = 1'b1; ad[inst] = 4'($urandom_range(0, 15));
    chk(inst, "after_load");
    step();
    rd[inst] = 1'b0;
  endtask

  task automatic randomCpu(input int inst, input int n);
    int op;
    for (int k = 0; k < n; k++) begin
      op = $urandom_range(0, 2);
      cpuOp(inst, op != 1, op != 0, 4'($urandom_range(0, 15)), 8'($urandom), "rand_cpu");
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      clrS[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; ls[i] = 1'b0; lv[i] = 1'b0;
      ad[i] = 4'h0; mi[i] = 8'h00; ld[i] = 8'h00;
      clearModel(i);
    end
    step(); step();
    clrS[0] = 1'b0; clrS[1] = 1'b0;

    // Reset then read
    rd[0] = 1'b1; ad[0] = 4'h3; rd[1] = 1'b1; ad[1] = 4'h3;
    chk(0, "reset_read"); chk(1, "reset_read");
    step();
    rd[0] = 1'b0; rd[1] = 1'b0;

    // CPU write/read and read-during-write
    cpuOp(0, 1'b0, 1'b1, 4'h5, 8'hC3, "write5");
    cpuOp(0, 1'b1, 1'b0, 4'h5, 8'h00, "read5");
    cpuOp(0, 1'b1, 1'b1, 4'h5, 8'h7E, "rw5_old");
    cpuOp(0, 1'b1, 1'b0, 4'h5, 8'h00, "read5_new");

    // Full load with back-to-back bytes
    doLoad(0, 16, 8'h10, -1, 0, 1'b0, 1'b0, -1, 1'b0);
    cpuOp(0, 1'b1, 1'b0, 4'hA, 8'h00, "readA");

    // Stall after byte 3
    doLoad(0, 16, -1, 3, 5, 1'b0, 1'b0, -1, 1'b0);
    for (int a = 0; a < 16; a++) cpuOp(0, 1'b1, 1'b0, 4'(a), 8'h00, "read_stall_load");

    // CPU write dropped during load, conflict flagged
    doLoad(0, 16, -1, 5, 2, 1'b1, 1'b1, -1, 1'b0);
    cpuOp(0, 1'b1, 1'b0, 4'h0, 8'h00, "read0_after_poke");
    clrS[0] = 1'b1;
    #1;
    clearModel(0);
    chk(0, "clr_conflict");
    step();
    clrS[0] = 1'b0;

    randomCpu(0, 30);
    doLoad(0, 16, -1, -1, 0, 1'b1, 1'b0, -1, 1'b1);
    randomCpu(0, 20);

    // Partial load preserves upper words, then abort mid-load
    cpuOp(1, 1'b0, 1'b1, 4'h9, 8'h55, "preload9");
    randomCpu(1, 10);
    doLoad(1, 4, -1, -1, 0, 1'b1, 1'b0, -1, 1'b0);
    for (int a = 0; a < 16; a++) cpuOp(1, 1'b1, 1'b0, 4'(a), 8'h00, "read_partial");
    doLoad(1, 4, -1, -1, 0, 1'b0, 1'b0, 2, 1'b0);
    for (int a = 0; a < 16; a++) cpuOp(1, 1'b1, 1'b0, 4'(a), 8'h00, "read_after_abort");
    randomCpu(1, 15);
    doLoad(1, 4, -1, -1, 0, 1'b1, 1'b0, -1, 1'b0);
    randomCpu(1, 10);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
